dsp_mac_array: RTL and testbench

- Parametrised, multi-channel successor to the single 8-bit pre-subtract MAC.
- Each of N_CH lanes computes P <= (A ± D) * B + Z through a 4-stage pipeline.
- Z is the lane's own accumulator, a preload value C, or zero.
- Adds valid gating (hold when idle), standalone clear, a per-transaction add/subtract pre-adder mode, and synchronous reset.
- Sits in the video-capture pixel datapath feeding filter/statistics logic. Structured so each lane maps onto one DSP48.

---
 rtl/dsp_mac_array.sv | 148 ++++++++++++++
 tb/tb_dsp_mac_array.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_array.sv
// N_CH-lane 4-stage pre-adder MAC: P <= (A +/- D) * B + {P | C | 0}, shared control.
// Define DSP_MAC_SAT_EN to clamp the accumulate to PW bits and add per-lane sat flags.
module dsp_mac_array #(
    parameter int unsigned N_CH = 2,
    parameter int unsigned AW   = 8,
    parameter int unsigned BW   = 8,
    parameter int unsigned PW   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 load,
    input  logic                 clear,
    input  logic                 pre_add,
    input  logic [N_CH*AW-1:0]   A,
    input  logic [N_CH*BW-1:0]   B,
    input  logic [N_CH*PW-1:0]   C,
    input  logic [N_CH*AW-1:0]   D,
    output logic [N_CH*PW-1:0]   P,
`ifdef DSP_MAC_SAT_EN
    output logic [N_CH-1:0]      sat,
`endif
    output logic                 out_valid_pre1,
    output logic                 out_valid
);
    localparam int unsigned MW = AW + 1 + BW;

    if (PW < MW) begin : g_pw_check
        $error("dsp_mac_array: PW must be >= AW+1+BW");
    end

    logic v1_q, ld1_q, cl1_q, pa1_q;
    logic v2_q, ld2_q, cl2_q;
    logic v3_q, ld3_q, cl3_q;
    logic out_valid_q;

    // Clear travels even without in_valid so a standalone clear still reaches stage 4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            ld1_q       <= 1'b0;
            cl1_q       <= 1'b0;
            pa1_q       <= 1'b0;
            v2_q        <= 1'b0;
            ld2_q       <= 1'b0;
            cl2_q       <= 1'b0;
            v3_q        <= 1'b0;
            ld3_q       <= 1'b0;
            cl3_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            v1_q        <= in_valid;
            ld1_q       <= load;
            cl1_q       <= clear;
            pa1_q       <= pre_add;
            v2_q        <= v1_q;
            ld2_q       <= ld1_q;
            cl2_q       <= cl1_q;
            v3_q        <= v2_q;
            ld3_q       <= ld2_q;
            cl3_q       <= cl2_q;
            out_valid_q <= v3_q;
        end
    end

    assign out_valid_pre1 = v3_q;
    assign out_valid      = out_valid_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        logic signed [AW-1:0] a1_q, d1_q;
        logic signed [BW-1:0] b1_q, b2_q;
        logic signed [AW:0]   ad_d, ad2_q;
        logic signed [MW-1:0] m_d, m3_q;
        logic signed [PW-1:0] c3_q, p_q, p_d, base;

        always_comb begin
            if (pa1_q) ad_d = {a1_q[AW-1], a1_q} + {d1_q[AW-1], d1_q};
            else       ad_d = {a1_q[AW-1], a1_q} - {d1_q[AW-1], d1_q};
        end

        assign m_d = MW'(ad2_q) * MW'(b2_q);

        always_comb begin
            base = p_q;
            if (cl3_q)      base = '0;
            else if (ld3_q) base = c3_q;
        end

`ifdef DSP_MAC_SAT_EN
        logic signed [PW:0] sum_w;
        logic               ovf;
        logic               sat_q, sat_d;

        always_comb begin
            sum_w = (PW+1)'(m3_q) + (PW+1)'(base);
            ovf   = sum_w[PW] != sum_w[PW-1];
            p_d   = p_q;
            sat_d = 1'b0;
            if (v3_q) begin
                sat_d = ovf;
                if (!ovf)          p_d = sum_w[PW-1:0];
                else if (sum_w[PW]) p_d = {1'b1, {(PW-1){1'b0}}};
                else               p_d = {1'b0, {(PW-1){1'b1}}};
            end else if (cl3_q) begin
                p_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) sat_q <= 1'b0;
            else        sat_q <= sat_d;
        end

        assign sat[k] = sat_q;
`else
        always_comb begin
            p_d = p_q;
            if (v3_q)       p_d = PW'(m3_q) + base;
            else if (cl3_q) p_d = '0;
        end
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                a1_q  <= '0;
                d1_q  <= '0;
                b1_q  <= '0;
                b2_q  <= '0;
                ad2_q <= '0;
                m3_q  <= '0;
                c3_q  <= '0;
                p_q   <= '0;
            end else begin
                a1_q  <= A[k*AW +: AW];
                d1_q  <= D[k*AW +: AW];
                b1_q  <= B[k*BW +: BW];
                b2_q  <= b1_q;
                ad2_q <= ad_d;
                m3_q  <= m_d;
                c3_q  <= C[k*PW +: PW];
                p_q   <= p_d;
            end
        end

        assign P[k*PW +: PW] = p_q;
    end

endmodule

// File: tb/tb_dsp_mac_array.sv
// Scoreboard bench for dsp_mac_array (N_CH=2, AW=BW=8, PW=24); honours DSP_MAC_SAT_EN.
module tb_dsp_mac_array;
    localparam int N_CH = 2;
    localparam int AW   = 8;
    localparam int BW   = 8;
    localparam int PW   = 24;

    logic                 clk, rst_n, in_valid, load, clear, pre_add;
    logic [N_CH*AW-1:0]   A, D;
    logic [N_CH*BW-1:0]   B;
    logic [N_CH*PW-1:0]   C, P;
    logic                 out_valid_pre1, out_valid;
`ifdef DSP_MAC_SAT_EN
    logic [N_CH-1:0]      sat;
`endif

    typedef struct {
        logic [N_CH*PW-1:0] p;
        logic [N_CH-1:0]    s;
    } exp_t;

    exp_t                 sb[$];
    logic signed [PW-1:0] mdl_p [N_CH];
    logic [N_CH*PW-1:0]   c_pend1, c_pend2;
    logic [3:0]           hist;
    int                   n_checks, n_fail;

    dsp_mac_array #(.N_CH(N_CH), .AW(AW), .BW(BW), .PW(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .load           (load),
        .clear          (clear),
        .pre_add        (pre_add),
        .A              (A),
        .B              (B),
        .C              (C),
        .D              (D),
        .P              (P),
`ifdef DSP_MAC_SAT_EN
        .sat            (sat),
`endif
        .out_valid_pre1 (out_valid_pre1),
        .out_valid      (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic longint lane_p(input int k);
        return longint'($signed(P[k*PW +: PW]));
    endfunction

    // Advance one edge, then check valids and pop the scoreboard on out_valid.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            hist = '0;
            for (int k = 0; k < N_CH; k++) chk("rst_P", lane_p(k), 0);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_out_valid_pre1", longint'(out_valid_pre1), 0);
        end else begin
            hist = {hist[2:0], in_valid};
            chk("out_valid_pre1", longint'(out_valid_pre1), longint'(hist[2]));
            chk("out_valid", longint'(out_valid), longint'(hist[3]));
            if (out_valid === 1'b1) begin
                chk("sb_nonempty", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    for (int k = 0; k < N_CH; k++)
                        chk("sb_P", lane_p(k), longint'($signed(e.p[k*PW +: PW])));
`ifdef DSP_MAC_SAT_EN
                    chk("sb_sat", longint'(sat), longint'(e.s));
`endif
                end
            end
        end
    endtask

    // Drive one cycle: lane 0 directed, other lanes random; C goes out two cycles later.
    task automatic cycle(input logic v, input logic ld, input logic cl, input logic pr,
                         input int a0, input int d0, input int b0, input int c0);
        logic [N_CH*AW-1:0] av, dv;
        logic [N_CH*BW-1:0] bv;
        logic [N_CH*PW-1:0] cv;
        longint             ai, di, bi, m, base, sum;
        logic               s;
        exp_t               e;
        av = (N_CH*AW)'($urandom);
        dv = (N_CH*AW)'($urandom);
        bv = (N_CH*BW)'($urandom);
        cv = (N_CH*PW)'({$urandom, $urandom});
        av[AW-1:0] = AW'(a0);
        dv[AW-1:0] = AW'(d0);
        bv[BW-1:0] = BW'(b0);
        cv[PW-1:0] = PW'(c0);
        in_valid = v;
        load     = ld;
        clear    = cl;
        pre_add  = pr;
        A        = av;
        D        = dv;
        B        = bv;
        C        = c_pend2;
        c_pend2  = c_pend1;
        c_pend1  = cv;
        if (v) begin
            e.s = '0;
            for (int k = 0; k < N_CH; k++) begin
                ai   = longint'($signed(av[k*AW +: AW]));
                di   = longint'($signed(dv[k*AW +: AW]));
                bi   = longint'($signed(bv[k*BW +: BW]));
                m    = (pr ? ai + di : ai - di) * bi;
                base = cl ? 0 : (ld ? longint'($signed(cv[k*PW +: PW])) : longint'(mdl_p[k]));
                sum  = m + base;
                s    = 1'b0;
`ifdef DSP_MAC_SAT_EN
                if (sum > 64'sd8388607) begin
                    sum = 8388607;
                    s   = 1'b1;
                end else if (sum < -64'sd8388608) begin
                    sum = -8388608;
                    s   = 1'b1;
                end
`endif
                mdl_p[k]           = sum[PW-1:0];
                e.p[k*PW +: PW]    = mdl_p[k];
                e.s[k]             = s;
            end
            sb.push_back(e);
        end else if (cl) begin
            for (int k = 0; k < N_CH; k++) mdl_p[k] = '0;
        end
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            in_valid = 1'(($urandom));
            load     = 1'(($urandom));
            clear    = 1'(($urandom));
            pre_add  = 1'(($urandom));
            A        = (N_CH*AW)'($urandom);
            D        = (N_CH*AW)'($urandom);
            B        = (N_CH*BW)'($urandom);
            C        = (N_CH*PW)'({$urandom, $urandom});
            tick();
        end
        rst_n = 1'b1;
        sb.delete();
        for (int k = 0; k < N_CH; k++) mdl_p[k] = '0;
        c_pend1 = '0;
        c_pend2 = '0;
    endtask

    task automatic chk_model(input string tag);
        for (int k = 0; k < N_CH; k++) chk(tag, lane_p(k), longint'(mdl_p[k]));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hist     = '0;
        c_pend1  = '0;
        c_pend2  = '0;
        for (int k = 0; k < N_CH; k++) mdl_p[k] = '0;

        // Reset with random inputs, then quiet cycles after release.
        do_reset(2);
        idle(4);
        chk_model("post_reset_P");

        // Load: (5-2)*3 + 100 = 109.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 5, 2, 3, 100);
        idle(3);
        chk("load_P0", lane_p(0), 109);

        // Back-to-back accumulate: +32640 then +128.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, -128, 127, -128, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, -128, 127, -128, 0);
        idle(4);
        chk("accum_P0", lane_p(0), 32877);

        // Hold while idle.
        idle(5);
        chk("hold_P0", lane_p(0), 32877);
        chk_model("hold_P");

        // Standalone clear: P zeroed, no out_valid.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        idle(4);
        chk("clear_P0", lane_p(0), 0);
        chk_model("clear_P");

        // Clear beats load: 2*2 + 0.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 2, 0, 2, 50);
        idle(4);
        chk("clr_ld_P0", lane_p(0), 4);

        // Overflow on load.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10, 0, 10, 8388600);
        idle(4);
`ifdef DSP_MAC_SAT_EN
        chk("ovf_P0", lane_p(0), 8388607);
`else
        chk("ovf_P0", lane_p(0), -8388516);
`endif

        // Mixed random traffic through the scoreboard.
        for (int i = 0; i < 20; i++)
            cycle(1'(($urandom)), 1'(($urandom)), 1'(($urandom_range(0, 3) == 0)),
                  1'(($urandom)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 65535)) - 32768);
        idle(5);
        chk_model("random_P");

        // Reset mid-flight: in-flight transactions discarded.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 7, 1, 9, 1000);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 3, 3, 3, 0);
        do_reset(1);
        idle(6);
        chk("midrst_P0", lane_p(0), 0);
        chk("midrst_P1", lane_p(1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
